// File: rtl/mips_issuer_pkg.sv
// Shared types, constants and the micro-op encoder for the MIPS instruction issuer.
// Register map and opcode/funct values must match the execution core.
package mips_issuer_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpAnd  = 3'd1,
        OpOr   = 3'd2,
        OpNor  = 3'd3,
        OpSll  = 3'd4,
        OpSrl  = 3'd5,
        OpAddi = 3'd6,
        OpRaw  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [5:0] OPC_RTYPE  = 6'b000000;
    localparam logic [5:0] OPC_ADDI   = 6'b001000;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;

    // Logical register 0..5 to the physical register numbers the core implements.
    function automatic logic [4:0] map_reg(input logic [2:0] r);
        logic [4:0] phys;
        case (r)
            3'd0:    phys = 5'd17;
            3'd1:    phys = 5'd18;
            3'd2:    phys = 5'd8;
            3'd3:    phys = 5'd23;
            3'd4:    phys = 5'd31;
            3'd5:    phys = 5'd16;
            default: phys = 5'd0;
        endcase
        return phys;
    endfunction

    function automatic logic [31:0] encode_op(
        input op_e         op,
        input logic [2:0]  dst,
        input logic [2:0]  src1,
        input logic [2:0]  src2,
        input logic [15:0] imm,
        input logic [31:0] raw
    );
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  shamt;
        logic [31:0] word;
        funct = FUNCT_ADD;
        rs    = map_reg(src1);
        shamt = 5'd0;
        case (op)
            OpAnd: funct = FUNCT_AND;
            OpOr:  funct = FUNCT_OR;
            OpNor: funct = FUNCT_NOR;
            OpSll: begin
                funct = FUNCT_SLL;
                rs    = 5'd0;
                shamt = imm[4:0];
            end
            OpSrl: begin
                funct = FUNCT_SRL;
                rs    = 5'd0;
                shamt = imm[4:0];
            end
            default: funct = FUNCT_ADD;
        endcase
        case (op)
            OpAddi:  word = {OPC_ADDI, map_reg(src1), map_reg(dst), imm};
            OpRaw:   word = raw;
            default: word = {OPC_RTYPE, rs, map_reg(src2), map_reg(dst), shamt, funct};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/mips_instr_issuer_if.sv
// Command, core and status signals of the MIPS instruction issuer.
// master = control/test side plus the core's responses; slave = the issuer itself.
interface mips_instr_issuer_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [2:0]       cmd_dst;
    logic [2:0]       cmd_src1;
    logic [2:0]       cmd_src2;
    logic [15:0]      cmd_imm;
    logic [31:0]      cmd_raw;
    logic             start;
    logic             mips_in_valid;
    logic [31:0]      mips_instruction;
    logic             mips_out_valid;
    logic             mips_instruction_fail;
    logic [15:0]      mips_out_0;
    logic [15:0]      mips_out_1;
    logic [15:0]      mips_out_2;
    logic [15:0]      mips_out_3;
    logic [15:0]      mips_out_4;
    logic [15:0]      mips_out_5;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] resp_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [95:0]      snap;
    logic             timeout_err;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm, cmd_raw, start,
        output mips_out_valid, mips_instruction_fail,
        output mips_out_0, mips_out_1, mips_out_2, mips_out_3, mips_out_4, mips_out_5,
        input  cmd_ready, mips_in_valid, mips_instruction, busy, done,
        input  resp_cnt, fail_cnt, snap, timeout_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm, cmd_raw, start,
        input  mips_out_valid, mips_instruction_fail,
        input  mips_out_0, mips_out_1, mips_out_2, mips_out_3, mips_out_4, mips_out_5,
        output cmd_ready, mips_in_valid, mips_instruction, busy, done,
        output resp_cnt, fail_cnt, snap, timeout_err
    );
endinterface

// File: rtl/mips_issuer_fifo.sv
// Synchronous FIFO holding encoded instruction words; synchronous active-high reset.
module mips_issuer_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // A pop frees the slot the same cycle, so push while full is fine if popping.
    assign w_push  = i_push && (!o_full || i_pop);
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mips_instr_issuer.sv
// Buffers micro-ops, encodes them to MIPS words and streams them to the core, tracking responses.
// Optional drain watchdog enabled by defining MIPS_ISSUER_TIMEOUT_EN.
module mips_instr_issuer
    import mips_issuer_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    mips_instr_issuer_if.slave bus
);
    localparam int unsigned OW = $clog2(DEPTH) + 2;

    state_e           r_state;
    state_e           w_state_next;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_enc_word;
    logic [31:0]      w_fifo_word;
    logic             w_resp;
    logic             w_start;
    logic             w_tmo_hit;
    logic             r_in_valid;
    logic [31:0]      r_instr;
    logic [OW-1:0]    r_outstanding;
    logic [CNT_W-1:0] r_resp_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [95:0]      r_snap;

    assign w_enc_word = encode_op(op_e'(bus.cmd_op), bus.cmd_dst, bus.cmd_src1, bus.cmd_src2,
                                  bus.cmd_imm, bus.cmd_raw);
    assign w_push  = bus.cmd_valid && !w_full;
    assign w_pop   = (r_state == StIssue) && !w_empty;
    assign w_resp  = bus.mips_out_valid && (r_state != StIdle);
    assign w_start = bus.start && (r_state == StIdle);

    mips_issuer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_enc_word),
        .i_pop   (w_pop),
        .o_data  (w_fifo_word),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.start) w_state_next = StIssue;
            StIssue: if (w_empty) w_state_next = StDrain;
            StDrain: if (r_outstanding == '0 || w_tmo_hit) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_valid <= 1'b0;
            r_instr    <= '0;
        end else begin
            r_in_valid <= w_pop;
            if (w_pop) begin
                r_instr <= w_fifo_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_tmo_hit) begin
            r_outstanding <= '0;
        end else begin
            case ({r_in_valid, w_resp})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Failed responses are counted but never overwrite the register snapshot.
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_resp_cnt <= '0;
            r_fail_cnt <= '0;
            r_snap     <= '0;
        end else if (w_resp) begin
            if (r_resp_cnt != {CNT_W{1'b1}}) begin
                r_resp_cnt <= r_resp_cnt + 1'b1;
            end
            if (bus.mips_instruction_fail) begin
                if (r_fail_cnt != {CNT_W{1'b1}}) begin
                    r_fail_cnt <= r_fail_cnt + 1'b1;
                end
            end else begin
                r_snap <= {bus.mips_out_5, bus.mips_out_4, bus.mips_out_3,
                           bus.mips_out_2, bus.mips_out_1, bus.mips_out_0};
            end
        end
    end

`ifdef MIPS_ISSUER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_tmo_err;

    assign w_tmo_hit = (r_state == StDrain) && !bus.mips_out_valid &&
                       (r_outstanding != '0) && (r_tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || r_state != StDrain || bus.mips_out_valid) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_tmo_err <= 1'b0;
        end else if (w_tmo_hit) begin
            r_tmo_err <= 1'b1;
        end
    end

    assign bus.timeout_err = r_tmo_err;
`else
    assign w_tmo_hit       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.cmd_ready        = !w_full;
    assign bus.mips_in_valid    = r_in_valid;
    assign bus.mips_instruction = r_instr;
    assign bus.busy             = (r_state != StIdle);
    assign bus.done             = (r_state == StDone);
    assign bus.resp_cnt         = r_resp_cnt;
    assign bus.fail_cnt         = r_fail_cnt;
    assign bus.snap             = r_snap;
endmodule
